// File: rtl/prog_seq.sv
// Program sequencer: PC, Start/Done run handshake, memory-latency stall and write gating.
// Define PROG_SEQ_PERF_EN to add the InstrCount/StallCount performance counter outputs.
module prog_seq #(
    parameter int T          = 10,
    parameter int W          = 8,
    parameter int MEM_LAT    = 2,
    parameter int START_ADDR = 0
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic         Done_in,
    input  logic         BranchEZ,
    input  logic         BranchNZ,
    input  logic         BranchAlways,
    input  logic [W-1:0] Target,
    input  logic [W-1:0] CondVal,
    input  logic         MemOp,
    input  logic         RegWrite_dec,
    input  logic         write_mem_dec,
    output logic [T-1:0] ProgCtr,
    output logic [T-1:0] ProgCtr_p1,
    output logic         RegWrite,
    output logic         write_mem,
    output logic         Stall,
    output logic         Running,
    output logic         Done
`ifdef PROG_SEQ_PERF_EN
    ,
    output logic [15:0]  InstrCount,
    output logic [15:0]  StallCount
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_WAIT = 2'd2,
        S_HALT = 2'd3
    } state_t;

    localparam logic [T-1:0] START_PC = T'(START_ADDR);
    localparam bit           HAS_LAT  = (MEM_LAT > 0);
    localparam logic [2:0]   LAT_LOAD = HAS_LAT ? 3'(MEM_LAT - 1) : 3'd0;

    state_t       state_q, state_d;
    logic [T-1:0] pc_q, pc_d;
    logic [2:0]   cnt_q, cnt_d;

    logic         commit;
    logic         start_run;
    logic         stall_int;
    logic         taken;
    logic [T-1:0] pc_p1;

    assign pc_p1 = pc_q + T'(1);
    assign taken = BranchAlways
                 | (BranchEZ & (CondVal == '0))
                 | (BranchNZ & (CondVal != '0));

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_d   = state_q;
        pc_d      = pc_q;
        cnt_d     = cnt_q;
        commit    = 1'b0;
        start_run = 1'b0;
        stall_int = 1'b0;

        unique case (state_q)
            S_IDLE, S_HALT: begin
                if (Start) begin
                    state_d   = S_RUN;
                    pc_d      = START_PC;
                    start_run = 1'b1;
                end
            end
            S_RUN: begin
                if (Done_in) begin
                    state_d = S_HALT;
                end else if (MemOp && HAS_LAT) begin
                    stall_int = 1'b1;
                    cnt_d     = LAT_LOAD;
                    state_d   = S_WAIT;
                end else begin
                    commit = 1'b1;
                end
            end
            S_WAIT: begin
                if (cnt_q != 3'd0) begin
                    stall_int = 1'b1;
                    cnt_d     = cnt_q - 3'd1;
                end else begin
                    commit  = 1'b1;
                    state_d = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Taken branches zero-extend the W-bit target, clearing the upper PC bits.
        if (commit) begin
            pc_d = taken ? T'(Target) : pc_p1;
        end
    end

    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (Reset) begin
            state_q <= S_IDLE;
            pc_q    <= START_PC;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Reset overrides the strobes combinationally so an interrupted commit never writes.
    assign ProgCtr    = pc_q;
    assign ProgCtr_p1 = pc_p1;
    assign RegWrite   = commit & RegWrite_dec & ~Reset;
    assign write_mem  = commit & write_mem_dec & ~Reset;
    assign Stall      = stall_int & ~Reset;
    assign Running    = (state_q == S_RUN) || (state_q == S_WAIT);
    assign Done       = (state_q == S_HALT);

`ifdef PROG_SEQ_PERF_EN
    logic [15:0] instr_cnt_q, instr_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        instr_cnt_d = instr_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (start_run) begin
            instr_cnt_d = '0;
            stall_cnt_d = '0;
        end else begin
            if (commit && (instr_cnt_q != 16'hFFFF)) instr_cnt_d = instr_cnt_q + 16'd1;
            if (stall_int && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            instr_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            instr_cnt_q <= instr_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign InstrCount = instr_cnt_q;
    assign StallCount = stall_cnt_q;
`else
    logic unused_start_run;
    assign unused_start_run = start_run;
`endif

endmodule

// File: tb/tb_prog_seq.sv
// Directed testbench for prog_seq (T=10, W=8, MEM_LAT=2, START_ADDR=0).
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_prog_seq;

    logic       Clk = 1'b0;
    logic       Reset, Start, Done_in, BranchEZ, BranchNZ, BranchAlways;
    logic [7:0] Target, CondVal;
    logic       MemOp, RegWrite_dec, write_mem_dec;
    logic [9:0] ProgCtr, ProgCtr_p1;
    logic       RegWrite, write_mem, Stall, Running, Done;
`ifdef PROG_SEQ_PERF_EN
    logic [15:0] InstrCount, StallCount;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 Clk = ~Clk;

    prog_seq #(.T(10), .W(8), .MEM_LAT(2), .START_ADDR(0)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Done_in(Done_in),
        .BranchEZ(BranchEZ), .BranchNZ(BranchNZ), .BranchAlways(BranchAlways),
        .Target(Target), .CondVal(CondVal), .MemOp(MemOp),
        .RegWrite_dec(RegWrite_dec), .write_mem_dec(write_mem_dec),
        .ProgCtr(ProgCtr), .ProgCtr_p1(ProgCtr_p1), .RegWrite(RegWrite),
        .write_mem(write_mem), .Stall(Stall), .Running(Running), .Done(Done)
`ifdef PROG_SEQ_PERF_EN
        , .InstrCount(InstrCount), .StallCount(StallCount)
`endif
    );

    typedef struct {
        logic       rst, start, dne, bez, bnz, bal;
        logic [7:0] tgt, cond;
        logic       mem, rwd, wmd;
        logic [9:0] pc;
        logic       rw, wm, st, run, dn;
    } vec_t;

    localparam int NV = 26;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic start, input logic dne,
                         input logic bez, input logic bnz, input logic bal,
                         input logic [7:0] tgt, input logic [7:0] cond,
                         input logic mem, input logic rwd, input logic wmd);
        @(negedge Clk);
        Reset = rst; Start = start; Done_in = dne;
        BranchEZ = bez; BranchNZ = bnz; BranchAlways = bal;
        Target = tgt; CondVal = cond;
        MemOp = mem; RegWrite_dec = rwd; write_mem_dec = wmd;
        #1;
    endtask

    task automatic plain();
        drive(0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    endtask

    initial begin
        logic [9:0] exp_p1;

        //          rst st dne bez bnz bal tgt    cond   mem rwd wmd   pc      rw wm st run dn
        vecs[0]  = '{0, 0, 0,  0,  0,  0,  8'h00, 8'h00, 0,  1,  0,    10'h000, 0, 0, 0, 0, 0};
        vecs[1]  = '{0, 1, 0,  0,  0,  0,  8'h00, 8'h00, 0,  1,  0,    10'h000, 0, 0, 0, 0, 0};
        vecs[2]  = '{0, 0, 0,  0,  0,  0,  8'h00, 8'h00, 0,  1,  0,    10'h000, 1, 0, 0, 1, 0};
        vecs[3]  = '{0, 0, 0,  0,  0,  0,  8'h00, 8'h00, 0,  0,  1,    10'h001, 0, 1, 0, 1, 0};
        vecs[4]  = '{0, 1, 0,  0,  0,  0,  8'h00, 8'h00, 0,  0,  0,    10'h002, 0, 0, 0, 1, 0};
        vecs[5]  = '{0, 0, 0,  1,  0,  0,  8'h40, 8'h00, 0,  0,  0,    10'h003, 0, 0, 0, 1, 0};
        vecs[6]  = '{0, 0, 0,  1,  0,  0,  8'h10, 8'h05, 0,  0,  0,    10'h040, 0, 0, 0, 1, 0};
        vecs[7]  = '{0, 0, 0,  0,  1,  0,  8'h20, 8'h05, 0,  0,  0,    10'h041, 0, 0, 0, 1, 0};
        vecs[8]  = '{0, 0, 0,  0,  1,  0,  8'h30, 8'h00, 0,  0,  0,    10'h020, 0, 0, 0, 1, 0};
        vecs[9]  = '{0, 0, 0,  0,  0,  1,  8'h05, 8'h00, 0,  0,  0,    10'h021, 0, 0, 0, 1, 0};
        vecs[10] = '{0, 0, 0,  0,  0,  0,  8'h00, 8'h00, 1,  1,  0,    10'h005, 0, 0, 1, 1, 0};
        vecs[11] = '{0, 0, 0,  0,  0,  0,  8'h00, 8'h00, 1,  1,  0,    10'h005, 0, 0, 1, 1, 0};
        vecs[12] = '{0, 0, 0,  0,  0,  0,  8'h00, 8'h00, 1,  1,  0,    10'h005, 1, 0, 0, 1, 0};
        vecs[13] = '{0, 0, 0,  0,  0,  0,  8'h00, 8'h00, 1,  0,  1,    10'h006, 0, 0, 1, 1, 0};
        vecs[14] = '{0, 0, 0,  0,  0,  0,  8'h00, 8'h00, 1,  0,  1,    10'h006, 0, 0, 1, 1, 0};
        vecs[15] = '{0, 0, 0,  0,  0,  0,  8'h00, 8'h00, 1,  0,  1,    10'h006, 0, 1, 0, 1, 0};
        vecs[16] = '{0, 0, 0,  0,  0,  0,  8'h00, 8'h00, 0,  0,  0,    10'h007, 0, 0, 0, 1, 0};
        vecs[17] = '{0, 0, 0,  0,  0,  0,  8'h00, 8'h00, 0,  0,  0,    10'h008, 0, 0, 0, 1, 0};
        vecs[18] = '{0, 0, 1,  0,  0,  0,  8'h00, 8'h00, 0,  1,  1,    10'h009, 0, 0, 0, 1, 0};
        vecs[19] = '{0, 0, 1,  0,  0,  0,  8'h00, 8'h00, 0,  1,  0,    10'h009, 0, 0, 0, 0, 1};
        vecs[20] = '{0, 1, 0,  0,  0,  0,  8'h00, 8'h00, 0,  0,  0,    10'h009, 0, 0, 0, 0, 1};
        vecs[21] = '{0, 0, 0,  0,  0,  0,  8'h00, 8'h00, 0,  0,  0,    10'h000, 0, 0, 0, 1, 0};
        vecs[22] = '{0, 0, 0,  0,  0,  0,  8'h00, 8'h00, 1,  1,  0,    10'h001, 0, 0, 1, 1, 0};
        vecs[23] = '{0, 0, 0,  0,  0,  0,  8'h00, 8'h00, 1,  1,  0,    10'h001, 0, 0, 1, 1, 0};
        vecs[24] = '{1, 0, 0,  0,  0,  0,  8'h00, 8'h00, 1,  1,  0,    10'h001, 0, 0, 0, 1, 0};
        vecs[25] = '{0, 0, 0,  0,  0,  0,  8'h00, 8'h00, 0,  0,  0,    10'h000, 0, 0, 0, 0, 0};

        Reset = 1'b1; Start = 1'b0; Done_in = 1'b0;
        BranchEZ = 1'b0; BranchNZ = 1'b0; BranchAlways = 1'b0;
        Target = '0; CondVal = '0; MemOp = 1'b0; RegWrite_dec = 1'b0; write_mem_dec = 1'b0;
        repeat (2) @(posedge Clk);

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rst, vecs[i].start, vecs[i].dne, vecs[i].bez, vecs[i].bnz,
                  vecs[i].bal, vecs[i].tgt, vecs[i].cond, vecs[i].mem, vecs[i].rwd, vecs[i].wmd);
            exp_p1 = vecs[i].pc + 10'd1;
            check($sformatf("v%0d ProgCtr", i),    32'(ProgCtr),    32'(vecs[i].pc));
            check($sformatf("v%0d ProgCtr_p1", i), 32'(ProgCtr_p1), 32'(exp_p1));
            check($sformatf("v%0d RegWrite", i),   32'(RegWrite),   32'(vecs[i].rw));
            check($sformatf("v%0d write_mem", i),  32'(write_mem),  32'(vecs[i].wm));
            check($sformatf("v%0d Stall", i),      32'(Stall),      32'(vecs[i].st));
            check($sformatf("v%0d Running", i),    32'(Running),    32'(vecs[i].run));
            check($sformatf("v%0d Done", i),       32'(Done),       32'(vecs[i].dn));
        end

        // Long run: a branch from above 0xFF clears upper bits, then the PC wraps at 0x3FF.
        drive(0, 1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        for (int i = 0; i < 'h180; i++) plain();
        drive(0, 0, 0, 0, 0, 1, 8'h7F, 8'h00, 0, 0, 0);
        check("hi pc before jmp", 32'(ProgCtr), 32'h180);
        plain();
        check("jmp clears upper", 32'(ProgCtr), 32'h07F);
        for (int i = 1; i < 'h380; i++) plain();
        plain();
        check("pc at top", 32'(ProgCtr), 32'h3FF);
        check("p1 wraps", 32'(ProgCtr_p1), 32'h000);
        plain();
        check("pc wrapped", 32'(ProgCtr), 32'h000);
        check("still running", 32'(Running), 32'h1);

`ifdef PROG_SEQ_PERF_EN
        drive(1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        plain();
        check("perf instr reset", 32'(InstrCount), 32'h0);
        check("perf stall reset", 32'(StallCount), 32'h0);
        drive(0, 1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        for (int i = 0; i < 4; i++) plain();
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 1, 1, 0);
        drive(0, 0, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        check("perf instr count", 32'(InstrCount), 32'h5);
        check("perf stall count", 32'(StallCount), 32'h2);
        check("perf pc after ldw", 32'(ProgCtr), 32'h5);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
